// File: rtl/dac_joy_scan.sv
// dac_joy_scan - DAC/joystick comparator with a hardware SAR axis scanner.
//
// CPU path: hilo compares the top DAC_W bits of the selected axis against the
// CPU-written dac; sound muxes dac/cassette/cartridge audio. Both registered.
// Scanner: successive-approximation conversion of every axis in turn, results
// readable per channel through rd_ch/rd_data.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   joy_axis            NUM_CH packed axes of AXIS_W bits
//   dac, sel, snden     CPU DAC value, comparator/sound select, sound enable
//   cas_snd, cart_snd   cassette / cartridge audio levels
//   hilo, sound         comparator result, sound level (1-cycle latency)
//   scan_start          single-cycle scan request (ignored unless idle)
//   scan_cont           continuous-scan request (JOY_CONT_SCAN_EN builds only)
//   scan_busy           high in SETUP/WAIT/DECIDE
//   scan_done           one-cycle pulse at end of each pass
//   res_valid           per-channel result valid
//   rd_ch, rd_data      result readback (1-cycle latency, 0 for rd_ch>=NUM_CH)
//
// Optional: define JOY_CONT_SCAN_EN to let scan_cont restart the scan from
// DONE without clearing res_valid.
module dac_joy_scan #(
  parameter int DAC_W  = 6,
  parameter int AXIS_W = 8,
  parameter int NUM_CH = 4,
  parameter int SETTLE = 2,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*AXIS_W-1:0] joy_axis,
  input  logic [DAC_W-1:0]         dac,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     snden,
  input  logic [DAC_W-1:0]         cas_snd,
  input  logic [DAC_W-1:0]         cart_snd,
  output logic                     hilo,
  output logic [DAC_W-1:0]         sound,
  input  logic                     scan_start,
  input  logic                     scan_cont,
  output logic                     scan_busy,
  output logic                     scan_done,
  output logic [NUM_CH-1:0]        res_valid,
  input  logic [SEL_W-1:0]         rd_ch,
  output logic [DAC_W-1:0]         rd_data
);

  localparam int SLOTS = 2**SEL_W;
  localparam int BIT_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WAIT, S_DECIDE, S_DONE} state_t;

  state_t                        r_state, w_next;
  logic [SEL_W-1:0]              r_ch;
  logic [DAC_W-1:0]              r_hold, r_acc;
  logic [BIT_W-1:0]              r_bit;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_CH-1:0][DAC_W-1:0]  r_result;
  logic [NUM_CH-1:0]             r_valid;
  logic                          r_hilo;
  logic [DAC_W-1:0]              r_sound, r_rd_data;

  // Select-indexed views padded with zeros to the full select range, so an
  // out-of-range sel/rd_ch reads 0 (and 0 > dac is never true for hilo).
  logic [SLOTS-1:0][DAC_W-1:0]   w_top, w_res;

  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < NUM_CH) begin : g_ch
      assign w_top[k] = joy_axis[k*AXIS_W+AXIS_W-1 -: DAC_W];
      assign w_res[k] = r_result[k];
    end else begin : g_pad
      assign w_top[k] = '0;
      assign w_res[k] = '0;
    end
  end

  // Low axis bits are below DAC resolution; scan_cont is unused by default.
  logic w_unused;
  assign w_unused = ^{joy_axis, scan_cont};

  // SAR step: try the current bit on top of the accumulated result.
  logic [DAC_W-1:0] w_trial, w_try, w_acc_nx;
  assign w_trial  = DAC_W'(1) << r_bit;
  assign w_try    = r_acc | w_trial;
  assign w_acc_nx = (r_hold >= w_try) ? w_try : r_acc;

  logic w_last_bit, w_last_ch, w_settled;
  assign w_last_bit = (r_bit == '0);
  assign w_last_ch  = (r_ch == SEL_W'(NUM_CH-1));
  assign w_settled  = (r_cnt == CNT_W'(SETTLE-1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (scan_start) w_next = S_SETUP;
      S_SETUP:  w_next = S_WAIT;
      S_WAIT:   if (w_settled) w_next = S_DECIDE;
      S_DECIDE: begin
        if (!w_last_bit)    w_next = S_WAIT;
        else if (w_last_ch) w_next = S_DONE;
        else                w_next = S_SETUP;
      end
      S_DONE: begin
`ifdef JOY_CONT_SCAN_EN
        w_next = scan_cont ? S_SETUP : S_IDLE;
`else
        w_next = S_IDLE;
`endif
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    scan_busy = 1'b0;
    scan_done = 1'b0;
    case (r_state)
      S_SETUP, S_WAIT, S_DECIDE: scan_busy = 1'b1;
      S_DONE:                    scan_done = 1'b1;
      default: ;
    endcase
  end

  // Scanner datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch     <= '0;
      r_hold   <= '0;
      r_acc    <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (scan_start) begin
          r_ch    <= '0;
          r_valid <= '0;
        end
        S_SETUP: begin
          // Snapshot so axis movement during conversion cannot corrupt it.
          r_hold <= w_top[r_ch];
          r_acc  <= '0;
          r_bit  <= BIT_W'(DAC_W-1);
          r_cnt  <= '0;
        end
        S_WAIT: r_cnt <= r_cnt + 1'b1;
        S_DECIDE: begin
          r_acc <= w_acc_nx;
          r_cnt <= '0;
          if (!w_last_bit) begin
            r_bit <= r_bit - 1'b1;
          end else begin
            r_result[r_ch] <= w_acc_nx;
            r_valid[r_ch]  <= 1'b1;
            if (!w_last_ch) r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: begin
`ifdef JOY_CONT_SCAN_EN
          // Automatic restart keeps res_valid; results update in place.
          if (scan_cont) r_ch <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // CPU-visible comparator, sound mux and readback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hilo    <= 1'b0;
      r_sound   <= '0;
      r_rd_data <= '0;
    end else begin
      r_hilo    <= (w_top[sel] > dac);
      r_rd_data <= w_res[rd_ch];
      if (!snden)               r_sound <= '0;
      else if (int'(sel) == 0)  r_sound <= dac;
      else if (int'(sel) == 1)  r_sound <= cas_snd;
      else if (int'(sel) == 2)  r_sound <= cart_snd;
      else                      r_sound <= '0;
    end
  end

  assign hilo      = r_hilo;
  assign sound     = r_sound;
  assign res_valid = r_valid;
  assign rd_data   = r_rd_data;

endmodule
